// File: rtl/elastic_skid_fifo_pkg.sv
// Shared stream helpers: count width and
// parameter legality predicates.
package stream_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) &&
           ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(
    input int depth,
    input int th
  );
    return (th >= 1) && (th <= depth);
  endfunction

endpackage

// File: rtl/elastic_skid_fifo_if.sv
// Valid/ready stream bundle around the
// elastic skid fifo, with fill-level outputs.
interface elastic_skid_fifo_if
  import stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic [CW-1:0]    o_count;
  logic             o_almost_full;

  modport master (
    output i_data,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_data,
    input  o_valid,
    input  o_count,
    input  o_almost_full
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_data,
    output o_valid,
    output o_count,
    output o_almost_full
  );

endinterface

// File: rtl/elastic_skid_fifo_mem.sv
// DEPTH x WIDTH register file: sync write,
// async read, contents never reset.
module elastic_buffer_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_skid_fifo.sv
// Elastic valid/ready buffer: DEPTH entries,
// registered ready, optional empty bypass.
module elastic_skid_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int BYPASS       = 1,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input logic             clk,
  input logic             rst,
  elastic_skid_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(DEPTH, AFULL_THRESH)) begin : g_bad_th
    $error("AFULL_THRESH must be in 1..DEPTH");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             ready_q;
  logic             empty;
  logic             bypass_taken;
  logic             in_fire;
  logic             out_fire;
  logic             wr_en;
  logic             rd_en;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rd_data;

  // Bypass only while empty, so order is kept.
  always_comb begin
    empty        = (count == '0);
    bypass_taken = (BYPASS != 0) && empty;
    in_fire      = bus.i_valid & ready_q;
    valid        = !empty;
    data         = rd_data;
    if (bypass_taken) begin
      valid = in_fire;
      data  = bus.i_data;
    end
    out_fire   = valid & bus.i_ready;
    wr_en      = in_fire & !(bypass_taken & out_fire);
    rd_en      = out_fire & !empty;
    count_next = count + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      ready_q <= (count_next < CW'(DEPTH));
    end
  end

  elastic_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign bus.o_valid       = valid;
  assign bus.o_data        = data;
  assign bus.o_ready       = ready_q;
  assign bus.o_count       = count;
  assign bus.o_almost_full =
    (count >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_elastic_skid_fifo.sv
// Scoreboard bench: DEPTH=4 bypass instance and
// DEPTH=2 registered-path instance.
module tb_elastic_skid_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cnt;
  logic [7:0] q[$];
  logic [7:0] e;

  elastic_skid_fifo_if #(.WIDTH(8), .DEPTH(4)) a_if();
  elastic_skid_fifo_if #(.WIDTH(8), .DEPTH(2)) b_if();

  elastic_skid_fifo #(
    .WIDTH(8), .DEPTH(4), .BYPASS(1), .AFULL_THRESH(3)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  elastic_skid_fifo #(
    .WIDTH(8), .DEPTH(2), .BYPASS(0), .AFULL_THRESH(1)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic test_reset();
    a_if.i_valid = 0; a_if.i_data = 0; a_if.i_ready = 0;
    b_if.i_valid = 0; b_if.i_data = 0; b_if.i_ready = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_if.o_ready !== 1'b0) begin failures++;
      $display("FAIL rst_ready got=%0b exp=0", a_if.o_ready); end
    checks++;
    if (a_if.o_valid !== 1'b0) begin failures++;
      $display("FAIL rst_valid got=%0b exp=0", a_if.o_valid); end
    checks++;
    if (a_if.o_count !== 3'd0) begin failures++;
      $display("FAIL rst_count got=%0d exp=0", a_if.o_count); end
    checks++;
    if (a_if.o_almost_full !== 1'b0) begin failures++;
      $display("FAIL rst_afull got=%0b exp=0", a_if.o_almost_full); end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (a_if.o_ready !== 1'b0) begin failures++;
      $display("FAIL rel_ready_pre got=%0b exp=0", a_if.o_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (a_if.o_ready !== 1'b1) begin failures++;
      $display("FAIL rel_ready_post got=%0b exp=1", a_if.o_ready); end
    checks++;
    if (b_if.o_ready !== 1'b1) begin failures++;
      $display("FAIL rel_b_ready got=%0b exp=1", b_if.o_ready); end
    checks++;
    if (a_if.o_valid !== 1'b0 || a_if.o_count !== 3'd0) begin
      failures++;
      $display("FAIL rel_idle got=v%0b c%0d exp=v0 c0",
               a_if.o_valid, a_if.o_count);
    end
  endtask

  task automatic test_bypass();
    q.delete();
    a_if.i_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_if.i_valid = 1;
      a_if.i_data  = 8'(8'h11 * (k + 1));
      #1;
      q.push_back(a_if.i_data);
      e = q.pop_front();
      checks++;
      if (a_if.o_valid !== 1'b1 || a_if.o_data !== e) begin
        failures++;
        $display("FAIL bypass_data got=v%0b %h exp=v1 %h",
                 a_if.o_valid, a_if.o_data, e);
      end
      checks++;
      if (a_if.o_count !== 3'd0) begin failures++;
        $display("FAIL bypass_count got=%0d exp=0", a_if.o_count); end
    end
    @(negedge clk);
    a_if.i_valid = 0;
    #1;
    checks++;
    if (a_if.o_valid !== 1'b0 || a_if.o_count !== 3'd0) begin
      failures++;
      $display("FAIL bypass_idle got=v%0b c%0d exp=v0 c0",
               a_if.o_valid, a_if.o_count);
    end
  endtask

  task automatic test_fill();
    int k;
    q.delete();
    cnt = 0;
    k   = 0;
    a_if.i_ready = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_if.i_valid = 1;
      a_if.i_data  = 8'hA0 + 8'(k);
      #1;
      checks++;
      if (a_if.o_ready !== (cnt < 4)) begin failures++;
        $display("FAIL fill_ready c=%0d got=%0b exp=%0b",
                 c, a_if.o_ready, cnt < 4); end
      checks++;
      if (a_if.o_count !== 3'(cnt)) begin failures++;
        $display("FAIL fill_count c=%0d got=%0d exp=%0d",
                 c, a_if.o_count, cnt); end
      checks++;
      if (a_if.o_almost_full !== (cnt >= 3)) begin failures++;
        $display("FAIL fill_afull c=%0d got=%0b exp=%0b",
                 c, a_if.o_almost_full, cnt >= 3); end
      checks++;
      if (a_if.o_valid !== 1'b1 || a_if.o_data !== 8'hA0) begin
        failures++;
        $display("FAIL fill_head c=%0d got=v%0b %h exp=v1 a0",
                 c, a_if.o_valid, a_if.o_data);
      end
      if (cnt < 4) begin
        q.push_back(a_if.i_data);
        cnt++;
        k++;
      end
    end
  endtask

  task automatic test_drain_from_full();
    int guard;
    @(negedge clk);
    a_if.i_ready = 1;
    #1;
    checks++;
    if (a_if.o_ready !== 1'b0) begin failures++;
      $display("FAIL full_ready got=%0b exp=0", a_if.o_ready); end
    e = q.pop_front();
    cnt--;
    checks++;
    if (a_if.o_valid !== 1'b1 || a_if.o_data !== e) begin
      failures++;
      $display("FAIL full_pop got=v%0b %h exp=v1 %h",
               a_if.o_valid, a_if.o_data, e);
    end
    @(negedge clk);
    a_if.i_ready = 0;
    #1;
    checks++;
    if (a_if.o_count !== 3'd3) begin failures++;
      $display("FAIL after_pop_count got=%0d exp=3", a_if.o_count); end
    checks++;
    if (a_if.o_ready !== 1'b1) begin failures++;
      $display("FAIL after_pop_ready got=%0b exp=1", a_if.o_ready); end
    q.push_back(a_if.i_data);
    cnt++;
    @(negedge clk);
    a_if.i_valid = 0;
    a_if.i_ready = 1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      #1;
      checks++;
      if (a_if.o_count !== 3'(cnt)) begin failures++;
        $display("FAIL drain_count got=%0d exp=%0d",
                 a_if.o_count, cnt); end
      e = q.pop_front();
      cnt--;
      checks++;
      if (a_if.o_valid !== 1'b1 || a_if.o_data !== e) begin
        failures++;
        $display("FAIL drain_data got=v%0b %h exp=v1 %h",
                 a_if.o_valid, a_if.o_data, e);
      end
      guard++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (a_if.o_valid !== 1'b0 || a_if.o_count !== 3'd0) begin
      failures++;
      $display("FAIL drain_end got=v%0b c%0d exp=v0 c0",
               a_if.o_valid, a_if.o_count);
    end
    checks++;
    if (a_if.o_ready !== 1'b1) begin failures++;
      $display("FAIL drain_ready got=%0b exp=1", a_if.o_ready); end
  endtask

  task automatic test_no_bypass_stream();
    logic ev;
    q.delete();
    b_if.i_ready = 1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      b_if.i_valid = (t < 10);
      b_if.i_data  = 8'(t);
      #1;
      ev = (t >= 1 && t <= 10);
      checks++;
      if (b_if.o_ready !== 1'b1) begin failures++;
        $display("FAIL nb_ready t=%0d got=%0b exp=1",
                 t, b_if.o_ready); end
      checks++;
      if (b_if.o_valid !== ev) begin failures++;
        $display("FAIL nb_valid t=%0d got=%0b exp=%0b",
                 t, b_if.o_valid, ev); end
      checks++;
      if (b_if.o_count !== 2'(ev)) begin failures++;
        $display("FAIL nb_count t=%0d got=%0d exp=%0d",
                 t, b_if.o_count, ev); end
      if (ev) begin
        e = q.pop_front();
        checks++;
        if (b_if.o_data !== e) begin failures++;
          $display("FAIL nb_data t=%0d got=%h exp=%h",
                   t, b_if.o_data, e); end
      end
      if (t < 10) q.push_back(8'(t));
    end
    b_if.i_valid = 0;
  endtask

  task automatic test_reset_midstream();
    a_if.i_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_if.i_valid = 1;
      a_if.i_data  = 8'hB0 + 8'(c);
    end
    @(negedge clk);
    a_if.i_valid = 0;
    #1;
    checks++;
    if (a_if.o_count !== 3'd3 || a_if.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=c%0d v%0b exp=c3 v1",
               a_if.o_count, a_if.o_valid);
    end
    rst = 0;
    a_if.i_valid = 1;
    a_if.i_data  = 8'hC0;
    #1;
    checks++;
    if (a_if.o_valid !== 1'b0 || a_if.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=v%0b r%0b exp=v0 r0",
               a_if.o_valid, a_if.o_ready);
    end
    checks++;
    if (a_if.o_count !== 3'd0) begin failures++;
      $display("FAIL mid_rst_count got=%0d exp=0", a_if.o_count); end
    q.delete();
    @(negedge clk);
    rst = 1;
    a_if.i_ready = 1;
    @(negedge clk);
    #1;
    checks++;
    if (a_if.o_ready !== 1'b1 || a_if.o_count !== 3'd0) begin
      failures++;
      $display("FAIL mid_rel got=r%0b c%0d exp=r1 c0",
               a_if.o_ready, a_if.o_count);
    end
    q.push_back(a_if.i_data);
    e = q.pop_front();
    checks++;
    if (a_if.o_valid !== 1'b1 || a_if.o_data !== e) begin
      failures++;
      $display("FAIL mid_first got=v%0b %h exp=v1 %h",
               a_if.o_valid, a_if.o_data, e);
    end
    @(negedge clk);
    a_if.i_valid = 0;
    #1;
    checks++;
    if (a_if.o_count !== 3'd0 || a_if.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_end got=c%0d v%0b exp=c0 v0",
               a_if.o_count, a_if.o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill();
    test_drain_from_full();
    test_no_bypass_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
